// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin burst arbiter driving a mux select with valid/ready toward the consumer.
// Grants one source for up to BURST_LEN beats, then always spends one IDLE cycle before re-arbitrating.
module rr_mux_arbiter #(
   parameter int NUM_SLCT_LNS = 2,
   parameter int BURST_LEN    = 4
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic [(2**NUM_SLCT_LNS)-1:0] i_req,
   output logic [(2**NUM_SLCT_LNS)-1:0] o_ready,
   output logic [(2**NUM_SLCT_LNS)-1:0] o_grant,
   output logic [NUM_SLCT_LNS-1:0]      o_select,
   output logic                         o_valid,
   input  logic                         i_out_ready,
   output logic                         o_busy
);
   localparam int N  = 2**NUM_SLCT_LNS;
   localparam int SW = NUM_SLCT_LNS;
   localparam int CW = $clog2(BURST_LEN+1);
   localparam logic [CW-1:0] LAST = CW'(BURST_LEN-1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t          r_state, w_state_nxt;
   logic [SW-1:0]   r_g, w_g_nxt;
   logic [SW-1:0]   r_ptr, w_ptr_nxt;
   logic [CW-1:0]   r_cnt, w_cnt_nxt;
   logic [SW-1:0]   w_win;
   logic            w_xfer;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_g     <= '0;
         r_ptr   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_g     <= w_g_nxt;
         r_ptr   <= w_ptr_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Scan downward so the requester closest to ptr is assigned last and wins.
   always_comb begin
      w_win = r_ptr;
      for (int k = N-1; k >= 0; k--)
         if (i_req[r_ptr + SW'(k)]) w_win = r_ptr + SW'(k);
   end

   assign o_busy   = (r_state == GRANT);
   assign o_select = r_g;
   assign o_valid  = o_busy & i_req[r_g];
   assign o_grant  = o_busy ? (N'(1) << r_g) : '0;
   assign o_ready  = (o_valid & i_out_ready) ? o_grant : '0;
   assign w_xfer   = o_valid & i_out_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_g_nxt     = r_g;
      w_ptr_nxt   = r_ptr;
      w_cnt_nxt   = r_cnt;
      if (r_state == IDLE) begin
         if (|i_req) begin
            w_state_nxt = GRANT;
            w_g_nxt     = w_win;
            w_cnt_nxt   = '0;
         end
      end else if (!i_req[r_g] || (w_xfer && r_cnt == LAST)) begin
         w_state_nxt = IDLE;
         w_ptr_nxt   = r_g + SW'(1);
         w_cnt_nxt   = '0;
      end else if (w_xfer) begin
         w_cnt_nxt   = r_cnt + CW'(1);
      end
   end
endmodule
